// File: rtl/mmio_uart_tx_if.sv
// Data-memory bus seen by the UART transmitter: processor store path in,
// read data and window-hit flag back out to the memory map.
interface mmio_uart_tx_if;
  logic        we;   // write strobe (MemWrite)
  logic [31:0] a;    // byte address (ALUResult)
  logic [31:0] wd;   // write data
  logic [31:0] rd;   // read data, combinational
  logic        hit;  // address falls inside the register window

  // Processor / memory-map side
  modport master (
    output we,
    output a,
    output wd,
    input  rd,
    input  hit
  );

  // UART register block side
  modport slave (
    input  we,
    input  a,
    input  wd,
    output rd,
    output hit
  );
endinterface

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter.
// Three-word register window (DATA, STATUS, DIV) on the data bus, a byte
// FIFO for queued writes and a serialiser with a per-frame baud divisor.
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_1000,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [15:0] DIV_RESET  = 16'd434
) (
  input  logic          clk,
  input  logic          reset,   // asynchronous, active low
  mmio_uart_tx_if.slave bus,
  output logic          tx
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  // Word offsets of the registers inside the window
  localparam logic [29:0] OFF_DATA   = 30'd0;
  localparam logic [29:0] OFF_STATUS = 30'd1;
  localparam logic [29:0] OFF_DIV    = 30'd2;

  // The pointer arithmetic relies on natural wrap-around, and the count
  // has to fit the 8-bit STATUS field.
  if (FIFO_DEPTH < 2 || FIFO_DEPTH > 128 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two between 2 and 128");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  // ---------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------
  logic [29:0] word_off;
  logic        sel_data;
  logic        sel_status;
  logic        sel_div;

  // Byte lanes a[1:0] are ignored; only the word address is decoded.
  assign word_off   = bus.a[31:2] - BASE_ADDR[31:2];
  assign sel_data   = (word_off == OFF_DATA);
  assign sel_status = (word_off == OFF_STATUS);
  assign sel_div    = (word_off == OFF_DIV);
  assign bus.hit    = sel_data | sel_status | sel_div;

  // Bus bits that no register looks at
  logic unused_bus_bits;
  assign unused_bus_bits = &{1'b0, bus.a[1:0], bus.wd[31:16]};

  // ---------------------------------------------------------------------
  // Register state
  // ---------------------------------------------------------------------
  state_t         state;
  logic [7:0]     fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [CW-1:0]  count;
  logic           overflow;
  logic [15:0]    div;
  logic [15:0]    frame_div;
  logic [15:0]    baud_cnt;
  logic [2:0]     bit_idx;
  logic [7:0]     shift;

  logic full;
  logic empty;
  logic busy;
  logic push_req;
  logic push;
  logic pop;
  logic baud_done;

  assign full  = (count == CW'(FIFO_DEPTH));
  assign empty = (count == '0);
  assign busy  = (state != S_IDLE);

  // The serialiser takes the head whenever it is idle and something is queued.
  assign pop = (state == S_IDLE) && !empty;

  // A push into a full FIFO still succeeds when the same edge pops a slot.
  assign push_req = bus.we && sel_data;
  assign push     = push_req && (!full || pop);

  // Last cycle of the current bit period
  assign baud_done = (baud_cnt == frame_div - 16'd1);

  // ---------------------------------------------------------------------
  // FIFO storage
  // ---------------------------------------------------------------------
  // Write the pushed byte into the slot at the tail pointer.
  // NOTE: the storage array has no reset; empty/count already say which
  // slots are valid, and a reset-free array maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= bus.wd[7:0];
    end
  end

  // Advance the FIFO pointers and occupancy count.
  // NOTE: state registers use non-blocking (<=) so every flop samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Sticky overflow: set by a dropped byte, cleared by writing 1 to STATUS[3].
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow <= 1'b0;
    end else if (push_req && !push) begin
      overflow <= 1'b1;
    end else if (bus.we && sel_status && bus.wd[3]) begin
      overflow <= 1'b0;
    end
  end

  // Baud divisor register; zero would stall the counter so it is stored as 1.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div <= DIV_RESET;
    end else if (bus.we && sel_div) begin
      div <= (bus.wd[15:0] == 16'd0) ? 16'd1 : bus.wd[15:0];
    end
  end

  // ---------------------------------------------------------------------
  // Serialiser
  // ---------------------------------------------------------------------
  // Frame sequencer with registered tx; each level holds for frame_div cycles.
  // frame_div is captured at pop so a DIV write only affects later frames.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      tx        <= 1'b1;
      shift     <= '0;
      frame_div <= 16'd1;
      baud_cnt  <= '0;
      bit_idx   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          tx <= 1'b1;
          if (pop) begin
            shift     <= fifo_mem[rd_ptr];
            frame_div <= div;
            baud_cnt  <= '0;
            tx        <= 1'b0;
            state     <= S_START;
          end
        end

        S_START: begin
          if (baud_done) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            tx       <= shift[0];
            state    <= S_DATA;
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end

        S_DATA: begin
          if (baud_done) begin
            baud_cnt <= '0;
            shift    <= shift >> 1;
            if (bit_idx == 3'd7) begin
              tx    <= 1'b1;
              state <= S_STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx      <= shift[1];
            end
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end

        S_STOP: begin
          if (baud_done) begin
            baud_cnt <= '0;
            state    <= S_IDLE;
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end

        default: begin
          tx    <= 1'b1;
          state <= S_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Read mux
  // ---------------------------------------------------------------------
  // Return STATUS or DIV for the addressed word; DATA and misses read zero.
  // NOTE: rd gets a default before the branches so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    bus.rd = '0;
    if (sel_status) begin
      bus.rd = {16'b0, 8'(count), 4'b0, overflow, empty, full, busy};
    end else if (sel_div) begin
      bus.rd = {16'b0, div};
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench for mmio_uart_tx. Expected serial waveforms come from
// the 8N1 frame definition (start, 8 data LSB first, stop, each held for
// the divisor) plus the one idle cycle between back-to-back frames.
module tb_mmio_uart_tx;

  localparam logic [31:0] BASE     = 32'h0000_1000;
  localparam logic [31:0] DATA_A   = BASE + 32'd0;
  localparam logic [31:0] STATUS_A = BASE + 32'd4;
  localparam logic [31:0] DIV_A    = BASE + 32'd8;

  logic clk = 1'b0;
  logic reset;
  logic tx;

  mmio_uart_tx_if bus ();

  mmio_uart_tx #(
    .BASE_ADDR (BASE),
    .FIFO_DEPTH(8),
    .DIV_RESET (16'd434)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus),
    .tx   (tx)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  bit cap_q[$];   // tx sampled once per cycle
  bit busy_q[$];  // rd[0] sampled alongside
  bit exp_q[$];   // expected tx levels

  // ---------------- bus helpers ----------------
  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    bus.a  = addr;
    bus.wd = data;
    bus.we = 1'b1;
    @(posedge clk);
    #1;
    bus.we = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] addr, output logic [31:0] data,
                          output logic hit);
    @(negedge clk);
    bus.a = addr;
    #1;
    data = bus.rd;
    hit  = bus.hit;
  endtask

  // ---------------- reference model ----------------
  task automatic model_frame(input logic [7:0] b, input int d);
    for (int k = 0; k < 10 * d; k++) begin
      int bi;
      bi = k / d;
      if (bi == 0)      exp_q.push_back(1'b0);
      else if (bi == 9) exp_q.push_back(1'b1);
      else              exp_q.push_back(b[bi-1]);
    end
  endtask

  task automatic model_idle(input int n);
    repeat (n) exp_q.push_back(1'b1);
  endtask

  task automatic capture(input int n);
    cap_q.delete();
    busy_q.delete();
    repeat (n) begin
      @(negedge clk);
      cap_q.push_back(tx);
      busy_q.push_back(bus.rd[0]);
    end
  endtask

  function automatic logic [127:0] pack_cap(input int start, input int len);
    logic [127:0] v;
    v = '0;
    for (int i = 0; i < len; i++) v[i] = cap_q[start+i];
    return v;
  endfunction

  function automatic logic [127:0] pack_exp(input int start, input int len);
    logic [127:0] v;
    v = '0;
    for (int i = 0; i < len; i++) v[i] = exp_q[start+i];
    return v;
  endfunction

  // Behavioural receiver: find a start bit, sample mid-bit, check stop.
  task automatic rx_byte(input int d, input int timeout, output logic [7:0] b,
                         output bit got, output bit stop_ok);
    int cur;
    int target;
    got = 1'b0;
    stop_ok = 1'b0;
    b = '0;
    for (int c = 0; c < timeout; c++) begin
      @(negedge clk);
      if (tx === 1'b0) begin
        got = 1'b1;
        break;
      end
    end
    if (got) begin
      cur = 0;
      for (int j = 0; j < 8; j++) begin
        target = (j + 1) * d + d / 2;
        repeat (target - cur) @(negedge clk);
        cur  = target;
        b[j] = tx;
      end
      target = 9 * d + d / 2;
      repeat (target - cur) @(negedge clk);
      cur = target;
      stop_ok = (tx === 1'b1);
      repeat (10 * d - cur) @(negedge clk);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [31:0] r;
    logic h;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (tx !== 1'b1) $display("FAIL reset_tx_in_reset: got %b want 1", tx);
    else n_pass++;
    @(negedge clk);
    reset = 1'b1;
    bus_read(STATUS_A, r, h);
    n_checks++;
    if (r !== 32'h4) $display("FAIL reset_status: got %h want 00000004", r);
    else n_pass++;
    n_checks++;
    if (tx !== 1'b1) $display("FAIL reset_tx: got %b want 1", tx);
    else n_pass++;
    bus_read(DATA_A, r, h);
    n_checks++;
    if (r !== 32'h0) $display("FAIL reset_data_read: got %h want 00000000", r);
    else n_pass++;
    bus_read(DIV_A, r, h);
    n_checks++;
    if (r !== 32'd434) $display("FAIL reset_div: got %0d want 434", r);
    else n_pass++;
    n_checks++;
    if (h !== 1'b1) $display("FAIL hit_1008: got %b want 1", h);
    else n_pass++;
    bus_read(BASE + 32'hC, r, h);
    n_checks++;
    if (h !== 1'b0) $display("FAIL hit_100c: got %b want 0", h);
    else n_pass++;
  endtask

  task automatic test_single_byte();
    logic [127:0] got_v, exp_v;
    int busy_cnt;
    bus_write(DIV_A, 32'd4);
    exp_q.delete();
    model_idle(2);
    model_frame(8'h55, 4);
    model_idle(3);
    fork
      begin
        bus_write(DATA_A, 32'h55);
        bus.a = STATUS_A;
      end
      capture(45);
    join
    got_v = pack_cap(0, 45);
    exp_v = pack_exp(0, 45);
    n_checks++;
    if (got_v !== exp_v) $display("FAIL single_wave: got %h want %h", got_v, exp_v);
    else n_pass++;
    busy_cnt = 0;
    for (int i = 0; i < 45; i++) busy_cnt += int'(busy_q[i]);
    n_checks++;
    if (busy_cnt != 40) $display("FAIL single_busy_cycles: got %0d want 40", busy_cnt);
    else n_pass++;
    n_checks++;
    if (busy_q[1] !== 1'b0 || busy_q[2] !== 1'b1 || busy_q[41] !== 1'b1 || busy_q[42] !== 1'b0)
      $display("FAIL single_busy_edges: got %b%b%b%b want 0110",
               busy_q[1], busy_q[2], busy_q[41], busy_q[42]);
    else n_pass++;
  endtask

  task automatic test_random_frames();
    logic [7:0] bytes [9];
    logic [127:0] got_v, exp_v;
    logic [31:0] r;
    logic h;
    int d, n, flen;
    for (int round = 0; round < 3; round++) begin
      d = int'($urandom_range(1, 6));
      n = int'($urandom_range(2, 9));
      flen = 10 * d + 1;
      for (int i = 0; i < n; i++) bytes[i] = 8'($urandom);
      bus_write(DIV_A, 32'(d));
      exp_q.delete();
      model_idle(2);
      for (int i = 0; i < n; i++) begin
        model_frame(bytes[i], d);
        model_idle(1);
      end
      model_idle(2);
      fork
        begin
          for (int i = 0; i < n; i++) bus_write(DATA_A, {24'b0, bytes[i]});
        end
        capture(exp_q.size());
      join
      for (int i = 0; i < n; i++) begin
        got_v = pack_cap(2 + i * flen, flen);
        exp_v = pack_exp(2 + i * flen, flen);
        n_checks++;
        if (got_v !== exp_v)
          $display("FAIL rand_frame r%0d f%0d div %0d byte %h: got %h want %h",
                   round, i, d, bytes[i], got_v, exp_v);
        else n_pass++;
      end
      bus_read(STATUS_A, r, h);
      n_checks++;
      if (r !== 32'h4) $display("FAIL rand_status_after r%0d: got %h want 00000004", round, r);
      else n_pass++;
    end
  endtask

  task automatic test_overflow();
    logic [7:0] rxb [9];
    bit rxg [9];
    bit rxs [9];
    logic [31:0] st1, st2, r;
    logic [7:0] eb;
    bit eg, es;
    logic h;
    bus_write(DIV_A, 32'd1000);
    fork
      begin
        for (int i = 0; i < 10; i++) bus_write(DATA_A, 32'(i));
        bus_read(STATUS_A, st1, h);
        bus_write(STATUS_A, 32'h8);
        bus_read(STATUS_A, st2, h);
        bus_write(DIV_A, 32'd2);
      end
      begin
        for (int i = 0; i < 9; i++)
          rx_byte((i == 0) ? 1000 : 2, (i == 0) ? 20 : 100, rxb[i], rxg[i], rxs[i]);
      end
    join
    n_checks++;
    if (st1 !== 32'h0000_080B) $display("FAIL ovf_status_full: got %h want 0000080b", st1);
    else n_pass++;
    n_checks++;
    if (st2 !== 32'h0000_0803) $display("FAIL ovf_status_cleared: got %h want 00000803", st2);
    else n_pass++;
    for (int i = 0; i < 9; i++) begin
      n_checks++;
      if (!rxg[i] || !rxs[i] || rxb[i] !== 8'(i))
        $display("FAIL ovf_rx_byte %0d: got %h (seen %0d stop %0d) want %h",
                 i, rxb[i], rxg[i], rxs[i], 8'(i));
      else n_pass++;
    end
    rx_byte(2, 60, eb, eg, es);
    n_checks++;
    if (eg) $display("FAIL ovf_dropped_byte: got frame %h want none", eb);
    else n_pass++;
    bus_read(STATUS_A, r, h);
    n_checks++;
    if (r !== 32'h4) $display("FAIL ovf_status_end: got %h want 00000004", r);
    else n_pass++;
  endtask

  task automatic test_div_change();
    logic [127:0] got_v, exp_v;
    bus_write(DIV_A, 32'd4);
    exp_q.delete();
    model_idle(2);
    model_frame(8'hA3, 4);
    model_idle(1);
    model_frame(8'h3C, 8);
    model_idle(3);
    fork
      begin
        bus_write(DATA_A, 32'hA3);
        repeat (10) @(negedge clk);
        bus_write(DIV_A, 32'd8);
        bus_write(DATA_A, 32'h3C);
      end
      capture(126);
    join
    got_v = pack_cap(2, 41);
    exp_v = pack_exp(2, 41);
    n_checks++;
    if (got_v !== exp_v) $display("FAIL divchg_frame1: got %h want %h", got_v, exp_v);
    else n_pass++;
    got_v = pack_cap(43, 80);
    exp_v = pack_exp(43, 80);
    n_checks++;
    if (got_v !== exp_v) $display("FAIL divchg_frame2: got %h want %h", got_v, exp_v);
    else n_pass++;
    got_v = pack_cap(123, 3);
    exp_v = pack_exp(123, 3);
    n_checks++;
    if (got_v !== exp_v) $display("FAIL divchg_tail: got %h want %h", got_v, exp_v);
    else n_pass++;
  endtask

  task automatic test_zero_div_decode();
    logic [31:0] r;
    logic h;
    int lows;
    bus_write(DIV_A, 32'd0);
    bus_read(DIV_A, r, h);
    n_checks++;
    if (r !== 32'd1) $display("FAIL zero_div: got %0d want 1", r);
    else n_pass++;
    bus_read(DIV_A | 32'h3, r, h);
    n_checks++;
    if (r !== 32'd1 || h !== 1'b1) $display("FAIL div_byte_lane: got %h hit %b want 00000001 hit 1", r, h);
    else n_pass++;
    bus_write(32'h0000_2000, 32'hFF);
    bus_read(32'h0000_2000, r, h);
    n_checks++;
    if (h !== 1'b0 || r !== 32'h0) $display("FAIL outside_window: got %h hit %b want 00000000 hit 0", r, h);
    else n_pass++;
    lows = 0;
    repeat (30) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    n_checks++;
    if (lows != 0) $display("FAIL outside_tx_idle: got %0d low cycles want 0", lows);
    else n_pass++;
    bus_read(STATUS_A, r, h);
    n_checks++;
    if (r !== 32'h4) $display("FAIL outside_status: got %h want 00000004", r);
    else n_pass++;
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] b0;
    logic [31:0] r;
    logic h;
    int lows;
    bus_write(DIV_A, 32'd4);
    b0 = 8'($urandom) & 8'hF7;
    bus_write(DATA_A, {24'b0, b0});
    bus_write(DATA_A, 32'($urandom_range(0, 255)));
    bus_write(DATA_A, 32'($urandom_range(0, 255)));
    repeat (16) @(negedge clk);
    n_checks++;
    if (tx !== 1'b0) $display("FAIL rst_mid_bit3: got %b want 0", tx);
    else n_pass++;
    #2;
    reset = 1'b0;
    #1;
    n_checks++;
    if (tx !== 1'b1) $display("FAIL rst_mid_tx: got %b want 1", tx);
    else n_pass++;
    bus_read(STATUS_A, r, h);
    n_checks++;
    if (r !== 32'h4) $display("FAIL rst_mid_status_held: got %h want 00000004", r);
    else n_pass++;
    @(negedge clk);
    reset = 1'b1;
    bus_read(STATUS_A, r, h);
    n_checks++;
    if (r !== 32'h4) $display("FAIL rst_mid_status: got %h want 00000004", r);
    else n_pass++;
    bus_read(DIV_A, r, h);
    n_checks++;
    if (r !== 32'd434) $display("FAIL rst_mid_div: got %0d want 434", r);
    else n_pass++;
    lows = 0;
    repeat (200) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    n_checks++;
    if (lows != 0) $display("FAIL rst_mid_no_frames: got %0d low cycles want 0", lows);
    else n_pass++;
  endtask

  // ---------------- sequence ----------------
  initial begin
    bus.we = 1'b0;
    bus.a  = '0;
    bus.wd = '0;
    test_reset();
    test_single_byte();
    test_random_frames();
    test_overflow();
    test_div_change();
    test_zero_div_decode();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Bound on total run time
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached after %0d checks", n_checks);
    $fatal(1);
  end

endmodule
